// File: rtl/div_pkg.sv
// ============================================================================
// Module  : div_pkg
// Brief   : Shared widths and FSM state encoding for the sequential divider.
// Revision: 1.0
// ============================================================================
`default_nettype none

package div_pkg;

    localparam int DIV_WIDTH = 32;
    localparam int CNT_W     = $clog2(DIV_WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } div_state_t;

endpackage

`default_nettype wire

// File: rtl/seq_divider_if.sv
// ============================================================================
// Module  : seq_divider_if
// Brief   : start/busy/done handshake and operand/result bundle of the divider.
// Revision: 1.0
// ============================================================================
`default_nettype none

interface seq_divider_if
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
);

    logic             start;
    logic             signed_op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] r;
    logic             div0;

    modport master (
        output start, signed_op, a, b,
        input  busy, done, q, r, div0
    );

    modport slave (
        input  start, signed_op, a, b,
        output busy, done, q, r, div0
    );

endinterface

`default_nettype wire

// File: rtl/div_sub_stage.sv
// ============================================================================
// Module  : div_sub_stage
// Brief   : Ripple full-adder subtractor x - y (inverted y, carry-in 1).
// Revision: 1.0
// ============================================================================
`default_nettype none

module div_sub_stage #(
    parameter int WIDTH = 33
) (
    input  wire logic [WIDTH-1:0] i_x,
    input  wire logic [WIDTH-1:0] i_y,
    output logic      [WIDTH-1:0] o_diff,
    output logic                  o_no_borrow
);

    logic [WIDTH:0] w_carry;

    assign w_carry[0] = 1'b1;

    for (genvar i = 0; i < WIDTH; i++) begin : g_fa
        logic w_yn;
        assign w_yn           = ~i_y[i];
        assign o_diff[i]      = i_x[i] ^ w_yn ^ w_carry[i];
        assign w_carry[i + 1] = (i_x[i] & w_yn) | (w_carry[i] & (i_x[i] ^ w_yn));
    end

    assign o_no_borrow = w_carry[WIDTH];

endmodule

`default_nettype wire

// File: rtl/seq_divider.sv
// ============================================================================
// Module  : seq_divider
// Brief   : Restoring shift-subtract divider, one quotient bit per clock.
// Revision: 1.0
// ============================================================================
`default_nettype none

module seq_divider
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  wire logic    clk,
    input  wire logic    rst_n,
    seq_divider_if.slave bus
);

    localparam int                 c_cnt_w    = $clog2(WIDTH);
    localparam logic [c_cnt_w-1:0] c_cnt_init = c_cnt_w'(WIDTH - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);

    div_state_t         r_state;
    div_state_t         w_state_nxt;
    logic [c_cnt_w-1:0] r_cnt;
    logic [WIDTH-1:0]   r_rem;
    logic [WIDTH-1:0]   r_dvd;
    logic [WIDTH-1:0]   r_dvs;
    logic [WIDTH-1:0]   r_q;
    logic [WIDTH-1:0]   r_r;
    logic               r_neg_q;
    logic               r_neg_r;
    logic               r_div0;

    logic [WIDTH:0]     w_partial;
    logic [WIDTH:0]     w_sub_x;
    logic [WIDTH:0]     w_sub_y;
    logic [WIDTH:0]     w_sub_diff;
    logic               w_sub_ok;
    logic [WIDTH:0]     w_neg_y;
    logic [WIDTH:0]     w_neg_diff;
    logic               w_neg_nb;
    logic [WIDTH-1:0]   w_abs_a;
    logic [WIDTH-1:0]   w_abs_b;
    logic               w_zero_div;
    logic               w_unused;

    assign w_partial  = {r_rem, r_dvd[WIDTH-1]};
    assign w_zero_div = (bus.b == '0);

    // The trial subtractor doubles as a negator: -a in IDLE, -R in FIX.
    always_comb begin
        w_sub_x = '0;
        w_sub_y = {1'b0, r_rem};
        case (r_state)
            IDLE: w_sub_y = {1'b0, bus.a};
            CALC: begin
                w_sub_x = w_partial;
                w_sub_y = {1'b0, r_dvs};
            end
            default: ;
        endcase
    end

    assign w_neg_y = (r_state == IDLE) ? {1'b0, bus.b} : {1'b0, r_dvd};

    div_sub_stage #(.WIDTH(WIDTH + 1)) u_trial (
        .i_x         (w_sub_x),
        .i_y         (w_sub_y),
        .o_diff      (w_sub_diff),
        .o_no_borrow (w_sub_ok)
    );

    div_sub_stage #(.WIDTH(WIDTH + 1)) u_neg (
        .i_x         ({(WIDTH + 1){1'b0}}),
        .i_y         (w_neg_y),
        .o_diff      (w_neg_diff),
        .o_no_borrow (w_neg_nb)
    );

    assign w_abs_a  = (bus.signed_op && bus.a[WIDTH-1]) ? w_sub_diff[WIDTH-1:0] : bus.a;
    assign w_abs_b  = (bus.signed_op && bus.b[WIDTH-1]) ? w_neg_diff[WIDTH-1:0] : bus.b;
    assign w_unused = ^{w_sub_diff[WIDTH], w_neg_diff[WIDTH], w_neg_nb};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (bus.start) w_state_nxt = w_zero_div ? DONE : CALC;
            CALC:    if (r_cnt == '0) w_state_nxt = FIX;
            FIX:     w_state_nxt = DONE;
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt   <= '0;
            r_rem   <= '0;
            r_dvd   <= '0;
            r_dvs   <= '0;
            r_q     <= '0;
            r_r     <= '0;
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
            r_div0  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.start && w_zero_div) begin
                        r_q    <= '0;
                        r_r    <= bus.a;
                        r_div0 <= 1'b1;
                    end else if (bus.start) begin
                        r_dvd   <= w_abs_a;
                        r_dvs   <= w_abs_b;
                        r_rem   <= '0;
                        r_cnt   <= c_cnt_init;
                        r_neg_q <= bus.signed_op & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
                        r_neg_r <= bus.signed_op & bus.a[WIDTH-1];
                    end
                end
                CALC: begin
                    // Dividend register shifts out on the left while quotient bits enter on the right.
                    r_cnt <= r_cnt - c_cnt_one;
                    r_dvd <= {r_dvd[WIDTH-2:0], w_sub_ok};
                    r_rem <= w_sub_ok ? w_sub_diff[WIDTH-1:0] : w_partial[WIDTH-1:0];
                end
                FIX: begin
                    r_q    <= r_neg_q ? w_neg_diff[WIDTH-1:0] : r_dvd;
                    r_r    <= r_neg_r ? w_sub_diff[WIDTH-1:0] : r_rem;
                    r_div0 <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign bus.busy = (r_state == CALC) || (r_state == FIX);
    assign bus.done = (r_state == DONE);
    assign bus.q    = r_q;
    assign bus.r    = r_r;
    assign bus.div0 = r_div0;

endmodule

`default_nettype wire

// File: tb/tb_seq_divider.sv
// ============================================================================
// Module  : tb_seq_divider
// Brief   : Directed table-driven bench for seq_divider plus handshake/reset sequences.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_seq_divider;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_err;

    seq_divider_if #(.WIDTH(32)) bus ();

    seq_divider #(.WIDTH(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       nm;
        logic        sgn;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] q;
        logic [31:0] r;
        logic        d0;
        int          lat;
        int          nbusy;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    // Latency counts falling edges after the accepting edge up to the one that sees done.
    task automatic run_op(input vec_t v);
        int n;
        int nb;
        bit seen;
        @(negedge clk);
        bus.start     = 1'b1;
        bus.signed_op = v.sgn;
        bus.a         = v.a;
        bus.b         = v.b;
        @(negedge clk);
        bus.start = 1'b0;
        bus.a     = ~v.a;
        bus.b     = ~v.b;
        n    = 1;
        nb   = 0;
        seen = 1'b0;
        while (!seen && n <= 100) begin
            if (bus.busy) nb++;
            if (bus.done) seen = 1'b1;
            else begin
                @(negedge clk);
                n++;
            end
        end
        chk({v.nm, " done seen"}, 32'(seen), 32'd1);
        chk({v.nm, " latency"}, 32'(n), 32'(v.lat));
        chk({v.nm, " busy cycles"}, 32'(nb), 32'(v.nbusy));
        chk({v.nm, " q"}, bus.q, v.q);
        chk({v.nm, " r"}, bus.r, v.r);
        chk({v.nm, " div0"}, 32'(bus.div0), 32'(v.d0));
        @(negedge clk);
        chk({v.nm, " done one cycle"}, 32'(bus.done), 32'd0);
    endtask

    initial begin
        int   n;
        int   k;
        int   pulses;
        vec_t v;

        n_checks = 0;
        n_err    = 0;

        vecs[0] = '{"udiv 100/7",        1'b0, 32'd100,        32'd7,          32'd14,         32'd2,          1'b0, 34, 33};
        vecs[1] = '{"sdiv -100/7",       1'b1, 32'hFFFFFF9C,   32'd7,          32'hFFFFFFF2,   32'hFFFFFFFE,   1'b0, 34, 33};
        vecs[2] = '{"sdiv 100/-7",       1'b1, 32'd100,        32'hFFFFFFF9,   32'hFFFFFFF2,   32'd2,          1'b0, 34, 33};
        vecs[3] = '{"sdiv -100/-7",      1'b1, 32'hFFFFFF9C,   32'hFFFFFFF9,   32'd14,         32'hFFFFFFFE,   1'b0, 34, 33};
        vecs[4] = '{"udiv by zero",      1'b0, 32'h12345678,   32'd0,          32'd0,          32'h12345678,   1'b1, 1,  0};
        vecs[5] = '{"sdiv min/-1",       1'b1, 32'h80000000,   32'hFFFFFFFF,   32'h80000000,   32'd0,          1'b0, 34, 33};
        vecs[6] = '{"udiv max/1",        1'b0, 32'hFFFFFFFF,   32'd1,          32'hFFFFFFFF,   32'd0,          1'b0, 34, 33};
        vecs[7] = '{"udiv 5/9",          1'b0, 32'd5,          32'd9,          32'd0,          32'd5,          1'b0, 34, 33};
        vecs[8] = '{"udiv max/max-1",    1'b0, 32'hFFFFFFFF,   32'hFFFFFFFE,   32'd1,          32'd1,          1'b0, 34, 33};
        vecs[9] = '{"sdiv min by zero",  1'b1, 32'h80000000,   32'd0,          32'd0,          32'h80000000,   1'b1, 1,  0};

        rst_n         = 1'b0;
        bus.start     = 1'b0;
        bus.signed_op = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        repeat (3) @(negedge clk);
        chk("reset busy", 32'(bus.busy), 32'd0);
        chk("reset done", 32'(bus.done), 32'd0);
        chk("reset q", bus.q, 32'd0);
        chk("reset r", bus.r, 32'd0);
        chk("reset div0", 32'(bus.div0), 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 10; i++) run_op(vecs[i]);

        // Operands changed and start re-pulsed mid-CALC must not disturb the op.
        @(negedge clk);
        bus.start = 1'b1; bus.signed_op = 1'b0; bus.a = 32'd1000; bus.b = 32'd10;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (9) @(negedge clk);
        bus.start = 1'b1; bus.signed_op = 1'b1; bus.a = 32'd7; bus.b = 32'd0;
        @(negedge clk);
        bus.start = 1'b0;
        k = 0;
        while (!bus.done && k < 60) begin
            @(negedge clk);
            k++;
        end
        chk("midcalc done seen", 32'(bus.done), 32'd1);
        chk("midcalc q", bus.q, 32'd100);
        chk("midcalc r", bus.r, 32'd0);
        chk("midcalc div0", 32'(bus.div0), 32'd0);

        // start during the DONE cycle is ignored.
        bus.start = 1'b1; bus.signed_op = 1'b0; bus.a = 32'd50; bus.b = 32'd5;
        @(negedge clk);
        chk("start in done busy", 32'(bus.busy), 32'd0);
        bus.start = 1'b0;
        @(negedge clk);
        chk("start in done busy later", 32'(bus.busy), 32'd0);
        chk("start in done no done", 32'(bus.done), 32'd0);
        chk("start in done q kept", bus.q, 32'd100);

        // Continuous start: one op every 35 cycles.
        bus.start = 1'b1; bus.signed_op = 1'b0; bus.a = 32'd9; bus.b = 32'd3;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.done && n < 60);
        chk("stream first done", 32'(bus.done), 32'd1);
        chk("stream first q", bus.q, 32'd3);
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!bus.done && k < 60);
        bus.start = 1'b0;
        chk("stream gap", 32'(k), 32'd35);
        chk("stream second q", bus.q, 32'd3);
        chk("stream second r", bus.r, 32'd0);

        v = '{"div0 pre-reset", 1'b0, 32'h0000CAFE, 32'd0, 32'd0, 32'h0000CAFE, 1'b1, 1, 0};
        run_op(v);

        // Asynchronous reset in the middle of CALC.
        @(negedge clk);
        bus.start = 1'b1; bus.signed_op = 1'b0; bus.a = 32'd1000; bus.b = 32'd7;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (14) @(negedge clk);
        chk("pre-abort busy", 32'(bus.busy), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("abort busy", 32'(bus.busy), 32'd0);
        chk("abort done", 32'(bus.done), 32'd0);
        chk("abort q", bus.q, 32'd0);
        chk("abort r", bus.r, 32'd0);
        chk("abort div0", 32'(bus.div0), 32'd0);
        repeat (2) @(negedge clk);
        rst_n  = 1'b1;
        pulses = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus.done) pulses++;
        end
        chk("abort no done pulse", 32'(pulses), 32'd0);

        v = '{"udiv 9/3 after reset", 1'b0, 32'd9, 32'd3, 32'd3, 32'd0, 1'b0, 34, 33};
        run_op(v);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d", n_err);
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
